if_id_branch_resolve: RTL and testbench

Sits directly downstream of the fetch stage. Holds the IF/ID pipeline register, resolves B/BR branches in decode, and drives the predictor and PC correction signals back into fetch. On a misprediction it squashes the wrongly fetched instruction with a one-cycle bubble. Optional saturating branch/mispredict counters support performance analysis.

---
 rtl/wisc_pkg.sv | 24 ++
 rtl/branch_cond_eval.sv | 32 +++
 rtl/if_id_branch_resolve.sv | 110 +++++++++++
 tb/tb_if_id_branch_resolve.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared ISA constants for decode-stage branch resolution: opcodes,
// branch condition codes and the bit positions of {Z,V,N} in the flag bus.
package wisc_pkg;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    CC_NEQ    = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OVFL   = 3'b110,
    CC_UNCOND = 3'b111
  } cc_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a 3-bit branch condition against {Z,V,N}; purely combinational,
// no state and no flow control.
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cc_e'(ccc))
      CC_NEQ:    taken = ~z;
      CC_EQ:     taken = z;
      CC_GT:     taken = ~z & ~n;
      CC_LT:     taken = n;
      CC_GTE:    taken = z | (~z & ~n);
      CC_LTE:    taken = n | z;
      CC_OVFL:   taken = v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_branch_resolve.sv
// IF/ID register plus decode-stage B/BR resolution; one-cycle fetch latency, combinational
// resolution, stall holds IF/ID and gates redirect/predictor writes. BRANCH_STATS_EN adds counters.
module if_id_branch_resolve
  import wisc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [WIDTH-1:0] PC_curr,
  input  logic [WIDTH-1:0] PC_inst,
  input  logic [1:0]       prediction,
  input  logic [WIDTH-1:0] predicted_target,
  input  logic [2:0]       flags,
  input  logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] IF_ID_PC_curr,
  output logic [WIDTH-1:0] IF_ID_inst,
  output logic             IF_ID_valid,
  output logic [1:0]       IF_ID_prediction,
  output logic             actual_taken,
  output logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] actual_target,
  output logic             update_PC,
  output logic             wen_BHT,
  output logic             wen_BTB
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mispred_count
`endif
);

  logic [WIDTH-1:0] IF_ID_pred_target;
  logic [3:0]       opcode;
  logic             is_b, is_brr, is_br;
  logic             cond_met;
  logic [WIDTH-1:0] pc_plus2;
  logic [WIDTH-1:0] b_offset;
  logic             target_miss;
  logic             mispredict;

  assign opcode = IF_ID_inst[WIDTH-1 -: 4];
  assign is_b   = IF_ID_valid & (opcode == OP_B);
  assign is_brr = IF_ID_valid & (opcode == OP_BR);
  assign is_br  = is_b | is_brr;

  branch_cond_eval u_cond (
    .ccc   (IF_ID_inst[11:9]),
    .flags (flags),
    .taken (cond_met)
  );

  // 9-bit word offset, sign-extended and scaled to bytes
  assign b_offset = {{(WIDTH-10){IF_ID_inst[8]}}, IF_ID_inst[8:0], 1'b0};
  assign pc_plus2 = IF_ID_PC_curr + WIDTH'(2);

  assign actual_taken  = is_br & cond_met;
  assign branch_target = is_brr ? rs_data : (pc_plus2 + b_offset);
  assign actual_target = actual_taken ? branch_target : pc_plus2;

  // A taken branch whose BTB target is stale counts as a mispredict even if direction was right
  assign target_miss = IF_ID_pred_target != branch_target;
  assign mispredict  = IF_ID_valid &
                       ((IF_ID_prediction[1] != actual_taken) | (actual_taken & target_miss));

  assign update_PC = mispredict & ~stall;
  assign wen_BHT   = is_br & ~stall;
  assign wen_BTB   = is_br & actual_taken & target_miss & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_PC_curr     <= '0;
      IF_ID_inst        <= '0;
      IF_ID_valid       <= 1'b0;
      IF_ID_prediction  <= 2'b00;
      IF_ID_pred_target <= '0;
    end else if (!stall) begin
      if (update_PC) begin
        IF_ID_PC_curr     <= '0;
        IF_ID_inst        <= '0;
        IF_ID_valid       <= 1'b0;
        IF_ID_prediction  <= 2'b00;
        IF_ID_pred_target <= '0;
      end else begin
        IF_ID_PC_curr     <= PC_curr;
        IF_ID_inst        <= PC_inst;
        IF_ID_valid       <= 1'b1;
        IF_ID_prediction  <= prediction;
        IF_ID_pred_target <= predicted_target;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (wen_BHT && (br_count != '1))
        br_count <= br_count + 1'b1;
      if (update_PC && is_br && (mispred_count != '1))
        mispred_count <= mispred_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_branch_resolve.sv
// Bench for if_id_branch_resolve: an ISA-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_if_id_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] PC_curr = '0;
  logic [15:0] PC_inst = '0;
  logic [1:0]  prediction = '0;
  logic [15:0] predicted_target = '0;
  logic [2:0]  flags = '0;
  logic [15:0] rs_data = '0;
  logic [15:0] IF_ID_PC_curr, IF_ID_inst, branch_target, actual_target;
  logic [1:0]  IF_ID_prediction;
  logic        IF_ID_valid, actual_taken, update_PC, wen_BHT, wen_BTB;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_count, mispred_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_id_branch_resolve #(.WIDTH(16), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .PC_curr(PC_curr), .PC_inst(PC_inst), .prediction(prediction),
    .predicted_target(predicted_target), .flags(flags), .rs_data(rs_data),
    .IF_ID_PC_curr(IF_ID_PC_curr), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid),
    .IF_ID_prediction(IF_ID_prediction), .actual_taken(actual_taken),
    .branch_target(branch_target), .actual_target(actual_target),
    .update_PC(update_PC), .wen_BHT(wen_BHT), .wen_BTB(wen_BTB)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .mispred_count(mispred_count)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ISA-level model ----------------
  logic        m_valid = 1'b0;
  logic [15:0] m_pc = '0, m_inst = '0, m_tgt = '0;
  logic [1:0]  m_pred = '0;
  int          m_br = 0, m_mis = 0;

  typedef struct {
    logic        taken;
    logic [15:0] bt;
    logic [15:0] at;
    logic        upd;
    logic        wbht;
    logic        wbtb;
    logic        isbr;
  } exp_t;

  function automatic logic cond_holds(input logic [2:0] cc, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (cc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t resolve(input logic [2:0] f, input logic [15:0] rs, input logic stl);
    exp_t e;
    int   off;
    logic is_b, is_r, mis;
    is_b = m_valid && (m_inst[15:12] == 4'hC);
    is_r = m_valid && (m_inst[15:12] == 4'hD);
    e.isbr = is_b || is_r;
    off = int'(m_inst[8:0]);
    if (off >= 256) off = off - 512;
    e.bt = is_r ? rs : 16'(int'(m_pc) + 2 + 2 * off);
    e.taken = e.isbr && cond_holds(m_inst[11:9], f);
    e.at = e.taken ? e.bt : 16'(m_pc + 16'd2);
    mis = m_valid && ((m_pred[1] != e.taken) || (e.taken && (m_tgt != e.bt)));
    e.upd  = mis && !stl;
    e.wbht = e.isbr && !stl;
    e.wbtb = e.isbr && e.taken && (m_tgt != e.bt) && !stl;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_valid = 1'b0; m_pc = '0; m_inst = '0; m_tgt = '0; m_pred = '0;
      m_br = 0; m_mis = 0;
    end else begin
      e = resolve(flags, rs_data, stall);
      if (e.wbht && m_br != 65535) m_br++;
      if (e.upd && e.isbr && m_mis != 65535) m_mis++;
      if (!stall) begin
        if (e.upd) begin
          m_valid = 1'b0; m_pc = '0; m_inst = '0; m_tgt = '0; m_pred = '0;
        end else begin
          m_valid = 1'b1; m_pc = PC_curr; m_inst = PC_inst;
          m_tgt = predicted_target; m_pred = prediction;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = resolve(flags, rs_data, stall);
    chk("m_if_pc",    IF_ID_PC_curr, m_pc);
    chk("m_if_inst",  IF_ID_inst, m_inst);
    chk("m_if_valid", 16'(IF_ID_valid), 16'(m_valid));
    chk("m_if_pred",  16'(IF_ID_prediction), 16'(m_pred));
    chk("m_taken",    16'(actual_taken), 16'(e.taken));
    chk("m_bt",       branch_target, e.bt);
    chk("m_at",       actual_target, e.at);
    chk("m_upd",      16'(update_PC), 16'(e.upd));
    chk("m_wbht",     16'(wen_BHT), 16'(e.wbht));
    chk("m_wbtb",     16'(wen_BTB), 16'(e.wbtb));
`ifdef BRANCH_STATS_EN
    chk("m_brcnt",    br_count, 16'(m_br));
    chk("m_miscnt",   mispred_count, 16'(m_mis));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic probe();
    @(negedge clk); #1;
  endtask

  task automatic fetch(input logic [15:0] pc, input logic [15:0] inst,
                       input logic [1:0] pred, input logic [15:0] tgt);
    PC_curr = pc; PC_inst = inst; prediction = pred; predicted_target = tgt;
  endtask

  initial begin
    logic [15:0] binst;
    repeat (2) @(posedge clk);
    probe();
    chk("rst_valid", 16'(IF_ID_valid), 16'h0);
    chk("rst_at", actual_target, 16'h0002);
    chk("rst_upd", 16'(update_PC), 16'h0);
    fetch(16'h0010, 16'hCE02, 2'b00, 16'h0000);
    #1 rst_n = 1'b1;

    // B uncond, predicted not-taken
    tick(); fetch(16'h0012, 16'h1000, 2'b00, 16'h0);
    probe();
    chk("t1_pc", IF_ID_PC_curr, 16'h0010);
    chk("t1_upd", 16'(update_PC), 16'h1);
    chk("t1_at", actual_target, 16'h0016);
    chk("t1_wbtb", 16'(wen_BTB), 16'h1);
    tick(); fetch(16'h0016, 16'h1000, 2'b00, 16'h0);
    probe();
    chk("t1_bubble", 16'(IF_ID_valid), 16'h0);

    // B EQ with Z=0, predicted taken
    tick(); fetch(16'h0030, 16'hC205, 2'b11, 16'h0020); flags = 3'b000;
    tick(); fetch(16'h0032, 16'h1000, 2'b00, 16'h0);
    probe();
    chk("t2_taken", 16'(actual_taken), 16'h0);
    chk("t2_upd", 16'(update_PC), 16'h1);
    chk("t2_at", actual_target, 16'h0032);
    chk("t2_wbtb", 16'(wen_BTB), 16'h0);

    // BR uncond, correctly predicted
    tick(); fetch(16'h0040, 16'hDE00, 2'b10, 16'h1234);
    tick(); fetch(16'h0042, 16'h1000, 2'b00, 16'h0); rs_data = 16'h1234;
    probe();
    chk("t3_upd", 16'(update_PC), 16'h0);
    chk("t3_wbht", 16'(wen_BHT), 16'h1);
    chk("t3_wbtb", 16'(wen_BTB), 16'h0);
    chk("t3_at", actual_target, 16'h1234);

    // stall for three cycles with a mispredicted branch in IF/ID
    tick(); fetch(16'h0050, 16'hCE02, 2'b00, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); stall = 1'b1; fetch(16'h0052 + 16'(2 * i), 16'h2000, 2'b00, 16'h0);
      probe();
      chk("t4_pc", IF_ID_PC_curr, 16'h0050);
      chk("t4_inst", IF_ID_inst, 16'hCE02);
      chk("t4_wbht", 16'(wen_BHT), 16'h0);
      chk("t4_upd", 16'(update_PC), 16'h0);
    end
    tick(); stall = 1'b0; fetch(16'h0060, 16'h1000, 2'b00, 16'h0);
    probe();
    chk("t4_rel_upd", 16'(update_PC), 16'h1);
    chk("t4_rel_at", actual_target, 16'h0056);
    chk("t4_rel_wbht", 16'(wen_BHT), 16'h1);

    // B at top of address space wraps
    tick(); fetch(16'hFFFE, 16'hCE01, 2'b11, 16'h0002);
    tick(); fetch(16'h0002, 16'h1000, 2'b00, 16'h0);
    probe();
    chk("t5_bt", branch_target, 16'h0002);
    chk("t5_upd", 16'(update_PC), 16'h0);

    // non-branch BTB alias predicted taken
    tick(); fetch(16'h0070, 16'h1234, 2'b11, 16'h0080);
    tick(); fetch(16'h0072, 16'h1000, 2'b00, 16'h0);
    probe();
    chk("t6_upd", 16'(update_PC), 16'h1);
    chk("t6_at", actual_target, 16'h0072);
    chk("t6_wbht", 16'(wen_BHT), 16'h0);

    // back-to-back: mispredict squashes the second branch
    tick(); fetch(16'h0060, 16'hCE02, 2'b00, 16'h0);
    tick(); fetch(16'h0062, 16'hCE02, 2'b00, 16'h0);
    tick(); fetch(16'h0066, 16'h1000, 2'b00, 16'h0);
    probe();
    chk("t7_squash", 16'(IF_ID_valid), 16'h0);

    // back-to-back: both correctly predicted
    tick(); fetch(16'h0080, 16'hCE02, 2'b11, 16'h0086);
    tick(); fetch(16'h0086, 16'hCE02, 2'b11, 16'h008C);
    probe();
    chk("t8_upd1", 16'(update_PC), 16'h0);
    tick(); fetch(16'h008C, 16'h1000, 2'b00, 16'h0);
    probe();
    chk("t8_pc2", IF_ID_PC_curr, 16'h0086);
    chk("t8_upd2", 16'(update_PC), 16'h0);

    // every condition against every flag combination (model-checked)
    for (int cc = 0; cc < 8; cc++) begin
      for (int fl = 0; fl < 8; fl++) begin
        binst = 16'hC000 | 16'(cc << 9) | 16'($urandom_range(0, 511));
        tick(); fetch(16'($urandom_range(0, 32767) * 2), binst, 2'($urandom_range(0, 3)),
                      16'($urandom_range(0, 65535)));
        tick(); flags = 3'(fl); fetch(16'h0200, 16'h1000, 2'b00, 16'h0);
      end
    end

    // async reset mid-cycle, then three branches with one mispredict
    tick(); fetch(16'h0040, 16'hDE00, 2'b10, 16'h1234); rs_data = 16'h1234;
    #3 rst_n = 1'b0;
    #1;
    chk("t9_rst_valid", 16'(IF_ID_valid), 16'h0);
    chk("t9_rst_upd", 16'(update_PC), 16'h0);
`ifdef BRANCH_STATS_EN
    chk("t9_rst_br", br_count, 16'h0);
    chk("t9_rst_mis", mispred_count, 16'h0);
`endif
    @(negedge clk); #2 rst_n = 1'b1;
    tick(); fetch(16'hFFFE, 16'hCE01, 2'b11, 16'h0002);
    tick(); fetch(16'h0100, 16'hCE02, 2'b00, 16'h0);
    tick(); fetch(16'h0102, 16'h1000, 2'b00, 16'h0);
    probe();
    chk("t9_upd", 16'(update_PC), 16'h1);
    tick(); fetch(16'h0106, 16'h1000, 2'b00, 16'h0);
    tick();
    probe();
`ifdef BRANCH_STATS_EN
    chk("t9_br", br_count, 16'd3);
    chk("t9_mis", mispred_count, 16'd1);
`endif
    chk("t9_valid", 16'(IF_ID_valid), 16'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
